// File: rtl/i2c_poll_sequencer_if.sv
// rtl/i2c_poll_sequencer_if.sv - go/done command bundle to the I2C master core plus the RAM write port
// Ports (master = sequencer side):
//   m_go, m_rw, m_nbyte, m_dev, m_reg, m_wdata  command towards the master core
//   m_ready, m_rdata, m_done, m_ack_err          response from the master core
//   ram_w, ram_wadd, ram_din                     display/local RAM write port
interface i2c_poll_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              m_go;
    logic              m_rw;
    logic [5:0]        m_nbyte;
    logic [6:0]        m_dev;
    logic [7:0]        m_reg;
    logic [7:0]        m_wdata;
    logic              m_ready;
    logic [7:0]        m_rdata;
    logic              m_done;
    logic              m_ack_err;
    logic              ram_w;
    logic [ADDR_W-1:0] ram_wadd;
    logic [7:0]        ram_din;

    modport master (
        output m_go, m_rw, m_nbyte, m_dev, m_reg, m_wdata,
        input  m_ready, m_rdata, m_done, m_ack_err,
        output ram_w, ram_wadd, ram_din
    );

    modport slave (
        input  m_go, m_rw, m_nbyte, m_dev, m_reg, m_wdata,
        output m_ready, m_rdata, m_done, m_ack_err,
        input  ram_w, ram_wadd, ram_din
    );
endinterface

// File: rtl/i2c_poll_sequencer.sv
// rtl/i2c_poll_sequencer.sv - round-robin multi-channel I2C transaction sequencer
// Polls NUM_CH configurable slave channels through the master core's go/done interface.
// Read bytes land in a RAM window at ch*MAX_BYTES+byte.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   enable, period        run polling rounds; idle cycles between rounds (0 = back-to-back)
//   cfg_we .. cfg_wdata   one-cycle strobe writing one channel's config entry
//   bus                   master-core command/response and RAM write port (master modport)
//   busy                  state is not IDLE
//   cur_ch                channel being served / last served
//   err_flags             sticky per-channel NACK/timeout flags
module i2c_poll_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int MAX_BYTES = 4,
    parameter int ADDR_W    = 5,
    parameter int TIMEOUT   = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [15:0]          period,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic                 cfg_en,
    input  logic                 cfg_rw,
    input  logic [6:0]           cfg_dev,
    input  logic [7:0]           cfg_reg,
    input  logic [5:0]           cfg_len,
    input  logic [7:0]           cfg_wdata,
    i2c_poll_sequencer_if.master bus,
    output logic                 busy,
    output logic [CH_W-1:0]      cur_ch,
    output logic [NUM_CH-1:0]    err_flags
);
    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam int                IDX_W    = CH_W + 1;
    localparam logic [IDX_W-1:0]  IDX_END  = IDX_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] SLOT_A   = ADDR_W'(MAX_BYTES);
    localparam logic [5:0]        MAX_LEN  = 6'(MAX_BYTES);
    // The timer reads 1 in the first XFER cycle, so this value marks the
    // TIMEOUT-th cycle counted from the m_go cycle.
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_XFER,
        S_GAP
    } state_t;

    state_t            state, state_nxt;
    // One bit wider than a channel index so "past the last channel" is representable.
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [CH_W-1:0]   scan_ch;
    logic              at_end;
    logic              ch_active;
    logic [5:0]        sel_nbyte;
    logic [15:0]       gap_cnt;
    logic              gap_done;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic [5:0]        bcnt;
    logic              byte_ok;
    logic              err_this;

    logic [NUM_CH-1:0] tbl_en;
    logic [NUM_CH-1:0] tbl_rw;
    logic [6:0]        tbl_dev   [NUM_CH];
    logic [7:0]        tbl_reg   [NUM_CH];
    logic [5:0]        tbl_len   [NUM_CH];
    logic [7:0]        tbl_wdata [NUM_CH];

    assign scan_ch  = idx[CH_W-1:0];
    assign at_end   = (idx == IDX_END);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign gap_done = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, period};
    // Strobes past the clamped length still arrive from the core but are dropped.
    assign byte_ok  = bus.m_ready && (bcnt < bus.m_nbyte);
    assign busy     = (state != S_IDLE);
    assign bus.m_go = (state == S_ISSUE);

    always_comb begin
        ch_active = 1'b0;
        sel_nbyte = 6'd1;
        if (!at_end && (int'(scan_ch) < NUM_CH)) begin
            ch_active = tbl_en[scan_ch] && !(tbl_rw[scan_ch] && (tbl_len[scan_ch] == 6'd0));
            if (tbl_rw[scan_ch]) begin
                sel_nbyte = (tbl_len[scan_ch] > MAX_LEN) ? MAX_LEN : tbl_len[scan_ch];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_SCAN;
                    idx_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (at_end) begin
                    if (period != 16'd0) begin
                        state_nxt = S_GAP;
                    end else begin
                        idx_nxt = '0;
                    end
                end else if (ch_active) begin
                    state_nxt = S_ISSUE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            S_ISSUE: begin
                state_nxt = S_XFER;
            end
            S_XFER: begin
                if (bus.m_done || tmo_hit) begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = enable ? S_SCAN : S_IDLE;
                end
            end
            S_GAP: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (gap_done) begin
                    state_nxt = S_SCAN;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            bcnt     <= '0;
            err_this <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
            if (state == S_ISSUE) begin
                tmo_cnt  <= TMO_W'(1);
                bcnt     <= '0;
                err_this <= 1'b0;
            end else if (state == S_XFER) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (byte_ok) begin
                    bcnt <= bcnt + 6'd1;
                end
                if (bus.m_ack_err) begin
                    err_this <= 1'b1;
                end
            end
        end
    end

    // Shadow copy of the selected entry: later cfg_we writes never disturb
    // a transaction already handed to the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_ch      <= '0;
            bus.m_rw    <= 1'b0;
            bus.m_nbyte <= '0;
            bus.m_dev   <= '0;
            bus.m_reg   <= '0;
            bus.m_wdata <= '0;
        end else if ((state == S_SCAN) && (state_nxt == S_ISSUE)) begin
            cur_ch      <= scan_ch;
            bus.m_rw    <= tbl_rw[scan_ch];
            bus.m_nbyte <= sel_nbyte;
            bus.m_dev   <= tbl_dev[scan_ch];
            bus.m_reg   <= tbl_reg[scan_ch];
            bus.m_wdata <= tbl_wdata[scan_ch];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ram_w    <= 1'b0;
            bus.ram_wadd <= '0;
            bus.ram_din  <= '0;
        end else begin
            bus.ram_w <= (state == S_XFER) && byte_ok && bus.m_rw;
            if ((state == S_XFER) && byte_ok && bus.m_rw) begin
                bus.ram_wadd <= ADDR_W'(cur_ch) * SLOT_A + ADDR_W'(bcnt);
                bus.ram_din  <= bus.m_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_en <= '0;
            tbl_rw <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tbl_dev[i]   <= '0;
                tbl_reg[i]   <= '0;
                tbl_len[i]   <= '0;
                tbl_wdata[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            tbl_en[cfg_ch]    <= cfg_en;
            tbl_rw[cfg_ch]    <= cfg_rw;
            tbl_dev[cfg_ch]   <= cfg_dev;
            tbl_reg[cfg_ch]   <= cfg_reg;
            tbl_len[cfg_ch]   <= cfg_len;
            tbl_wdata[cfg_ch] <= cfg_wdata;
        end
    end

    // Later assignments take priority: a fresh error beats both the
    // reconfiguration clear and the clean-completion clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flags <= '0;
        end else begin
            if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
                err_flags[cfg_ch] <= 1'b0;
            end
            if (state == S_XFER) begin
                if (bus.m_done && !err_this && !bus.m_ack_err) begin
                    err_flags[cur_ch] <= 1'b0;
                end
                if (bus.m_ack_err || (tmo_hit && !bus.m_done)) begin
                    err_flags[cur_ch] <= 1'b1;
                end
            end
        end
    end
endmodule
